// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/stall control, write-back bypass on load
// and stall refresh of held operands, plus saturating stall/bubble event counters.
module id_ex_reg #(
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          stall,
   input  logic          flush,
   input  logic          id_valid,
   input  logic [DW-1:0] id_pc,
   input  logic [4:0]    id_rs,
   input  logic [4:0]    id_rt,
   input  logic [4:0]    id_dst,
   input  logic [DW-1:0] id_rd1,
   input  logic [DW-1:0] id_rd2,
   input  logic [DW-1:0] id_imm,
   input  logic [CW-1:0] id_ctrl,
   input  logic          id_regwrite,
   input  logic          wb_regwrite,
   input  logic [4:0]    wb_a3,
   input  logic [DW-1:0] wb_wd,
   output logic          ex_valid,
   output logic [DW-1:0] ex_pc,
   output logic [4:0]    ex_rs,
   output logic [4:0]    ex_rt,
   output logic [4:0]    ex_dst,
   output logic [DW-1:0] ex_a,
   output logic [DW-1:0] ex_b,
   output logic [DW-1:0] ex_imm,
   output logic [CW-1:0] ex_ctrl,
   output logic          ex_regwrite,
   output logic [15:0]   stall_cnt,
   output logic [15:0]   bubble_cnt
);

   logic          wb_live;
   logic          load_hit_a;
   logic          load_hit_b;
   logic          hold_hit_a;
   logic          hold_hit_b;
   logic          stall_ev;
   logic          bubble_ev;

   logic          nxt_valid;
   logic [DW-1:0] nxt_pc;
   logic [4:0]    nxt_rs;
   logic [4:0]    nxt_rt;
   logic [4:0]    nxt_dst;
   logic [DW-1:0] nxt_a;
   logic [DW-1:0] nxt_b;
   logic [DW-1:0] nxt_imm;
   logic [CW-1:0] nxt_ctrl;
   logic          nxt_regwrite;

   // Register 0 is hardwired, so a write-back to it must never be forwarded.
   assign wb_live    = wb_regwrite && (wb_a3 != 5'd0);
   assign load_hit_a = wb_live && (wb_a3 == id_rs);
   assign load_hit_b = wb_live && (wb_a3 == id_rt);
   assign hold_hit_a = wb_live && (wb_a3 == ex_rs);
   assign hold_hit_b = wb_live && (wb_a3 == ex_rt);

   assign stall_ev  = stall && !flush;
   assign bubble_ev = flush || (!stall && !id_valid);

   always_comb begin
      nxt_valid    = ex_valid;
      nxt_pc       = ex_pc;
      nxt_rs       = ex_rs;
      nxt_rt       = ex_rt;
      nxt_dst      = ex_dst;
      nxt_a        = ex_a;
      nxt_b        = ex_b;
      nxt_imm      = ex_imm;
      nxt_ctrl     = ex_ctrl;
      nxt_regwrite = ex_regwrite;
      if (flush || (!stall && !id_valid)) begin
         nxt_valid    = 1'b0;
         nxt_pc       = flush ? '0 : id_pc;
         nxt_rs       = '0;
         nxt_rt       = '0;
         nxt_dst      = '0;
         nxt_a        = '0;
         nxt_b        = '0;
         nxt_imm      = '0;
         nxt_ctrl     = '0;
         nxt_regwrite = 1'b0;
      end else if (stall) begin
         // Held operands pick up write-backs so they are current when the stall ends.
         if (hold_hit_a) nxt_a = wb_wd;
         if (hold_hit_b) nxt_b = wb_wd;
      end else begin
         nxt_valid    = 1'b1;
         nxt_pc       = id_pc;
         nxt_rs       = id_rs;
         nxt_rt       = id_rt;
         nxt_dst      = id_dst;
         nxt_a        = load_hit_a ? wb_wd : id_rd1;
         nxt_b        = load_hit_b ? wb_wd : id_rd2;
         nxt_imm      = id_imm;
         nxt_ctrl     = id_ctrl;
         nxt_regwrite = id_regwrite;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs       <= '0;
         ex_rt       <= '0;
         ex_dst      <= '0;
         ex_a        <= '0;
         ex_b        <= '0;
         ex_imm      <= '0;
         ex_ctrl     <= '0;
         ex_regwrite <= 1'b0;
      end else begin
         ex_valid    <= nxt_valid;
         ex_pc       <= nxt_pc;
         ex_rs       <= nxt_rs;
         ex_rt       <= nxt_rt;
         ex_dst      <= nxt_dst;
         ex_a        <= nxt_a;
         ex_b        <= nxt_b;
         ex_imm      <= nxt_imm;
         ex_ctrl     <= nxt_ctrl;
         ex_regwrite <= nxt_regwrite;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall_ev && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
         if (bubble_ev && (bubble_cnt != 16'hFFFF))
            bubble_cnt <= bubble_cnt + 16'd1;
      end
   end

endmodule
